store_drain: RTL and testbench
==============================

STORE_DRAIN -- requirements
Module: store_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of retired-store buffer entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port st_push, input, 1 bit: the retire stage is committing an LSQ entry this cycle.
REQ-005 SHALL have port st_addr, input, Address (64 bits): store byte address.
REQ-006 SHALL have port st_data, input, MemoryWord (64 bits): store data, right-aligned.
REQ-007 SHALL have port st_size, input, int: store size in bytes (0 means not a store).
REQ-008 SHALL have port ld_addr, input, Address: address of a load probing for conflicts.
REQ-009 SHALL have port mem_ready, input, 1 bit: the memory accepts a write.
REQ-010 SHALL have port mem_valid, output, 1 bit: a write request is presented.
REQ-011 SHALL have port mem_addr, output, Address: 8-byte-aligned write address.
REQ-012 SHALL have port mem_data, output, MemoryWord: lane-shifted write data.
REQ-013 SHALL have port mem_be, output, 8 bits: byte enables.
REQ-014 SHALL have port full, output, 1 bit: drives retire_stall.
REQ-015 SHALL have port empty, output, 1 bit: no buffered stores.
REQ-016 SHALL have port ld_conflict, output, 1 bit: a buffered store overlaps the ld_addr doubleword.
REQ-017 SHALL have port misalign, output, 1 bit: sticky flag for a doubleword-crossing store.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag for a push attempted while full.

Function
REQ-019 Push SHALL be accepted when st_push=1, st_size is in {1,2,4,8}, full=0 and no misalignment exists; otherwise the buffer SHALL be unchanged.
REQ-020 On push, the entry SHALL store addr = {st_addr[63:3],3'b0}, be = ((1<<st_size)-1) << st_addr[2:0], and data = st_data << (8*st_addr[2:0]), all truncated to 64/8 bits.
REQ-021 A store is misaligned when st_addr[2:0] + st_size > 8; it SHALL NOT be pushed and SHALL set misalign until reset.
REQ-022 An st_push with st_size=0 SHALL be ignored silently, with no flag set.
REQ-023 The buffer SHALL be a circular FIFO with head and tail pointers and a count from 0 to DEPTH; pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 mem_valid SHALL equal (count != 0); mem_addr, mem_data and mem_be SHALL present the head entry combinationally from registers.
REQ-025 A pop SHALL occur when mem_valid && mem_ready; the head SHALL advance on that edge.
REQ-026 mem_valid SHALL NOT drop, and the head fields SHALL NOT change, while a request is waiting for mem_ready.
REQ-027 Latency SHALL be one cycle: a store pushed at edge N SHALL be visible on mem_* after edge N when the buffer was empty. There SHALL be no same-cycle bypass.
REQ-028 A simultaneous push and pop SHALL leave count unchanged. When count=DEPTH, the push SHALL be rejected even if a pop occurs in that cycle.
REQ-029 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both derived from registered count.
REQ-030 A push while full with a valid st_size SHALL set overflow until reset and SHALL drop the store.
REQ-031 ld_conflict SHALL be 1 when any occupied entry has addr[63:3] == ld_addr[63:3]; it SHALL be combinational and SHALL ignore unoccupied entries.
REQ-032 Committed stores SHALL NOT be affected by pipeline flush; the block SHALL have no flush input.
REQ-033 Stores SHALL drain in strict program (push) order.

Reset
REQ-034 Reset SHALL asynchronously clear head, tail, count, misalign and overflow. This makes mem_valid=0, full=0, empty=1 and ld_conflict=0, with mem_addr, mem_data and mem_be driven to 0.
REQ-035 Reset asserted mid-drain SHALL discard all entries, including a pending unaccepted write.
REQ-036 Entry data storage need not be reset, but outputs SHALL read 0 while empty.

Verification
REQ-037 Single store: push SW with st_addr=0x1004 and st_data=0xDEADBEEF, with mem_ready=1. Required: next cycle mem_addr=0x1000, mem_be=0xF0, mem_data=0xDEADBEEF_00000000; the cycle after, empty=1.
REQ-038 Fill and backpressure: with mem_ready=0, push 4 SB stores. Required: full=1. A 5th push sets overflow=1 and leaves count=4; setting mem_ready=1 drains the stores in order over 4 cycles.
REQ-039 Simultaneous events: at count=2, push and pop in the same cycle. Required: count stays 2 and the tail wraps correctly across index 3 to 0.
REQ-040 Misalignment: push SD at st_addr=0x2003. Required: nothing enqueued, misalign=1, and misalign stays set on later valid stores.
REQ-041 Conflict: buffer holds SH at 0x3006 and the bench probes ld_addr. Required: ld_addr=0x3000 gives ld_conflict=1, ld_addr=0x3008 gives 0, and ld_conflict goes to 0 after the entry drains.
REQ-042 Reset mid-operation: assert reset while mem_valid=1 and mem_ready=0. Required: mem_valid=0 immediately, without waiting for a clock edge, and after release empty=1 with all flags 0.

Source files
------------

// File: rtl/store_drain.sv
// store_drain: retired-store buffer that drains committed stores to memory.
//
// Holds up to DEPTH doubleword-aligned write requests in a circular FIFO and
// presents the oldest one on the mem_* port until the memory accepts it.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   st_push          retire stage commits a store this cycle
//   st_addr/st_data  store byte address and right-aligned data
//   st_size          store size in bytes (1, 2, 4 or 8; 0 = not a store)
//   ld_addr          load address probed for doubleword conflicts
//   mem_ready        memory accepts the presented write
//   mem_valid        write request presented (buffer not empty)
//   mem_addr/data/be head entry: aligned address, lane-shifted data, byte enables
//   full, empty      buffer occupancy
//   ld_conflict      some buffered store touches the ld_addr doubleword
//   misalign         sticky: a doubleword-crossing store was rejected
//   overflow         sticky: a store arrived while the buffer was full
module store_drain #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_push,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  int          st_size,
    input  logic [63:0] ld_addr,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    output logic [7:0]  mem_be,
    output logic        full,
    output logic        empty,
    output logic        ld_conflict,
    output logic        misalign,
    output logic        overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q, misalign_d;
    logic          overflow_q, overflow_d;

    // Entry storage is not reset; outputs are masked while empty.
    logic [63:0] addr_mem [DEPTH];
    logic [63:0] data_mem [DEPTH];
    logic [7:0]  be_mem   [DEPTH];

    logic        size_ok;
    logic [2:0]  lane;
    logic [3:0]  lane_end;
    logic        store_misaligned;
    logic        push_fire;
    logic        pop_fire;
    logic [7:0]  be_base;
    logic [7:0]  push_be;
    logic [63:0] push_data;
    logic [63:0] push_addr;

    logic        unused_ld_lane;
    assign unused_ld_lane = ^ld_addr[2:0];

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign mem_valid = !empty;
    assign misalign  = misalign_q;
    assign overflow  = overflow_q;

    assign mem_addr = mem_valid ? addr_mem[head_q] : 64'h0;
    assign mem_data = mem_valid ? data_mem[head_q] : 64'h0;
    assign mem_be   = mem_valid ? be_mem[head_q]   : 8'h0;

    // Store decode and next-state.
    always_comb begin
        size_ok   = (st_size == 1) || (st_size == 2) || (st_size == 4) || (st_size == 8);
        lane      = st_addr[2:0];
        lane_end  = {1'b0, lane} + st_size[3:0];
        store_misaligned = size_ok && (lane_end > 4'd8);

        be_base = 8'h00;
        case (st_size[3:0])
            4'd1:    be_base = 8'h01;
            4'd2:    be_base = 8'h03;
            4'd4:    be_base = 8'h0F;
            4'd8:    be_base = 8'hFF;
            default: be_base = 8'h00;
        endcase
        push_be   = be_base << lane;
        push_data = st_data << {lane, 3'b000};
        push_addr = {st_addr[63:3], 3'b000};

        // A full buffer rejects the push even if the head drains this cycle.
        push_fire = st_push && size_ok && !store_misaligned && !full;
        pop_fire  = mem_valid && mem_ready;

        head_d  = pop_fire  ? head_q + PW'(1) : head_q;
        tail_d  = push_fire ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push_fire) - CW'(pop_fire);

        misalign_d = misalign_q | (st_push && store_misaligned);
        overflow_d = overflow_q | (st_push && size_ok && full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_mem[tail_q] <= push_addr;
            data_mem[tail_q] <= push_data;
            be_mem[tail_q]   <= push_be;
        end
    end

    // An entry is occupied when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] offset;
        ld_conflict = 1'b0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head_q;
            if (({1'b0, offset} < count_q) && (addr_mem[i][63:3] == ld_addr[63:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_drain.sv
module tb_store_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_push = 1'b0;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    int          st_size = 0;
    logic [63:0] ld_addr = '0;
    logic        mem_ready = 1'b0;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_be;
    logic        full;
    logic        empty;
    logic        ld_conflict;
    logic        misalign;
    logic        overflow;

    store_drain #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_push    (st_push),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_size    (st_size),
        .ld_addr    (ld_addr),
        .mem_ready  (mem_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_be     (mem_be),
        .full       (full),
        .empty      (empty),
        .ld_conflict(ld_conflict),
        .misalign   (misalign),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: a queue of pending writes plus the two sticky flags.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } entry_t;

    entry_t q[$];
    bit     m_mis = 1'b0;
    bit     m_ovf = 1'b0;

    function automatic logic [7:0] model_be(input int sz, input int lane);
        logic [15:0] m;
        m = 16'(((1 << sz) - 1) << lane);
        return m[7:0];
    endfunction

    function automatic bit model_size_ok(input int sz);
        return (sz == 1) || (sz == 2) || (sz == 4) || (sz == 8);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_mis <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            if (st_push && model_size_ok(st_size)) begin
                if (int'(st_addr[2:0]) + st_size > 8) m_mis <= 1'b1;
                if (q.size() == DEPTH) m_ovf <= 1'b1;
            end
            if (mem_ready && q.size() != 0) void'(q.pop_front());
            // Capacity is judged on the occupancy before this cycle's drain.
            if (st_push && model_size_ok(st_size) && (int'(st_addr[2:0]) + st_size <= 8) &&
                (q.size() + ((mem_ready && q.size() != 0) ? 1 : 0) < DEPTH)) begin
                q.push_back('{addr: {st_addr[63:3], 3'b000},
                              data: st_data << (8 * int'(st_addr[2:0])),
                              be:   model_be(st_size, int'(st_addr[2:0]))});
            end
        end
    end

    // Every cycle: compare all outputs with the model.
    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        foreach (q[i]) if (q[i].addr[63:3] == ld_addr[63:3]) hit = 1'b1;
        chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        chk("mem_addr", mem_addr, (q.size() != 0) ? q[0].addr : 64'h0);
        chk("mem_data", mem_data, (q.size() != 0) ? q[0].data : 64'h0);
        chk("mem_be", 64'(mem_be), (q.size() != 0) ? 64'(q[0].be) : 64'h0);
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("ld_conflict", 64'(ld_conflict), 64'(hit));
        chk("misalign", 64'(misalign), 64'(m_mis));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    end

    // Apply one cycle of inputs; returns just after the following negedge.
    task automatic step(input bit push, input logic [63:0] a, input logic [63:0] d,
                        input int sz, input bit rdy, input logic [63:0] la);
        st_push   = push;
        st_addr   = a;
        st_data   = d;
        st_size   = sz;
        mem_ready = rdy;
        ld_addr   = la;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_valid", 64'(mem_valid), 64'h0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);

        // Single SW, one-cycle latency then drained.
        step(1, 64'h1004, 64'hDEADBEEF, 4, 1, 0);
        chk("sw_addr", mem_addr, 64'h1000);
        chk("sw_be", 64'(mem_be), 64'hF0);
        chk("sw_data", mem_data, 64'hDEADBEEF_00000000);
        step(0, 0, 0, 0, 1, 0);
        chk("sw_drained", 64'(empty), 64'h1);

        // Fill with four SB under backpressure, then overflow attempt.
        for (int i = 0; i < 4; i++) step(1, 64'h10 + 64'(i), 64'hA1 + 64'(i), 1, 0, 0);
        chk("fill_full", 64'(full), 64'h1);
        step(1, 64'h14, 64'hA5, 1, 0, 0);
        chk("ovf_flag", 64'(overflow), 64'h1);
        chk("ovf_full", 64'(full), 64'h1);
        chk("drain0_be", 64'(mem_be), 64'h01);
        step(0, 0, 0, 0, 1, 0);
        chk("drain1_be", 64'(mem_be), 64'h02);
        chk("drain1_data", mem_data, 64'hA200);
        step(0, 0, 0, 0, 1, 0);
        chk("drain2_be", 64'(mem_be), 64'h04);
        step(0, 0, 0, 0, 1, 0);
        chk("drain3_data", mem_data, 64'hA4_000000);
        step(0, 0, 0, 0, 1, 0);
        chk("drain_empty", 64'(empty), 64'h1);

        // Push+pop at count 2 while the tail wraps.
        step(1, 64'h40, 64'h1, 8, 0, 0);
        step(1, 64'h48, 64'h2, 8, 0, 0);
        step(1, 64'h50, 64'h3, 8, 1, 0);
        chk("pp1_head", mem_addr, 64'h48);
        step(1, 64'h58, 64'h4, 8, 1, 0);
        chk("pp2_head", mem_addr, 64'h50);
        chk("pp2_notfull", 64'(full), 64'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("pp3_head", mem_addr, 64'h58);
        chk("pp3_data", mem_data, 64'h4);
        step(0, 0, 0, 0, 1, 0);
        chk("pp_empty", 64'(empty), 64'h1);

        // Misaligned SD rejected; flag is sticky.
        step(1, 64'h2003, 64'h55, 8, 0, 0);
        chk("mis_flag", 64'(misalign), 64'h1);
        chk("mis_empty", 64'(empty), 64'h1);
        step(1, 64'h2000, 64'h66, 4, 0, 0);
        chk("mis_sticky", 64'(misalign), 64'h1);
        chk("mis_valid_push", 64'(empty), 64'h0);
        step(0, 0, 0, 0, 1, 0);

        // Load conflict probe on an SH at 0x3006.
        step(1, 64'h3006, 64'hBEEF, 2, 0, 64'h3000);
        chk("cf_hit", 64'(ld_conflict), 64'h1);
        chk("cf_be", 64'(mem_be), 64'hC0);
        step(0, 0, 0, 0, 0, 64'h3008);
        chk("cf_miss", 64'(ld_conflict), 64'h0);
        step(0, 0, 0, 0, 1, 64'h3000);
        chk("cf_drained", 64'(ld_conflict), 64'h0);

        // Asynchronous reset with a pending, unaccepted write.
        step(1, 64'h5000, 64'h1234, 4, 0, 64'h5000);
        chk("rs_pending", 64'(mem_valid), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("rs_async_valid", 64'(mem_valid), 64'h0);
        chk("rs_async_addr", mem_addr, 64'h0);
        chk("rs_async_conf", 64'(ld_conflict), 64'h0);
        step(0, 0, 0, 0, 0, 64'h5000);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 64'h5000);
        chk("rs_empty", 64'(empty), 64'h1);
        chk("rs_mis", 64'(misalign), 64'h0);
        chk("rs_ovf", 64'(overflow), 64'h0);
        chk("rs_full", 64'(full), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
